// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller.
//   rx_state_e      : receive sequencer states (3-bit binary)
//   PAR_EVEN/PAR_ODD: PAR_TYP encodings
//   PRESCALE_8/16   : legal oversampling ratios
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Sampler / system-side bundle of the UART receive controller.
//   master (controller): drives S_EN, edge_count, P_DATA, Data_Valid, Par_Err, Stp_Err;
//                        reads sampled, Sampled_bit from the majority sampler.
//   slave  (sampler + system side): the mirror image.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 5
);
    logic                  S_EN;
    logic [PRESCALE_W-1:0] edge_count;
    logic                  sampled;
    logic                  Sampled_bit;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;

    modport master (
        output S_EN, edge_count, P_DATA, Data_Valid, Par_Err, Stp_Err,
        input  sampled, Sampled_bit
    );

    modport slave (
        input  S_EN, edge_count, P_DATA, Data_Valid, Par_Err, Stp_Err,
        output sampled, Sampled_bit
    );
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and frame bit counter.
//   clk, rst_n    : clock, async active-low reset
//   i_en          : count edges (high while a frame is in progress)
//   i_clr         : clear both counters (wins over i_en)
//   i_bit_en      : advance the bit counter at each bit end
//   i_prescale    : latched oversampling ratio
//   o_edge_count  : edge index within the current bit
//   o_bit_count   : number of bits completed while i_bit_en was high
//   o_bit_end     : current cycle is the last edge of the bit
module uart_rx_edge_bit_counter #(
    parameter int PRESCALE_W = 5,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic                  i_bit_en,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic [PRESCALE_W-1:0] o_edge_count,
    output logic [CNT_W-1:0]      o_bit_count,
    output logic                  o_bit_end
);

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [PRESCALE_W-1:0] w_last_edge;

    assign w_last_edge  = i_prescale - 1'b1;
    assign o_bit_end    = i_en && (r_edge_cnt == w_last_edge);
    assign o_edge_count = r_edge_cnt;
    assign o_bit_count  = r_bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_clr) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_en) begin
            if (o_bit_end) begin
                r_edge_cnt <= '0;
                if (i_bit_en) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else begin
                r_edge_cnt <= r_edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, bit timing, LSB-first
// deserialisation, parity and stop checking.
//   CLK, Reset      : oversampling clock, async active-low reset
//   RX_IN           : synchronised serial line (idle high)
//   Prescale        : oversampling ratio (8 or 16), latched at frame start
//   PAR_EN, PAR_TYP : parity present / odd parity, latched at frame start
//   rx_if (master)  : sampler handshake and received byte with status pulses
//
// state  | meaning
// IDLE   | line idle, counters held at 0, waiting for RX_IN low
// START  | timing the start bit; a high decision is treated as a glitch
// DATA   | shifting in DATA_WIDTH payload bits
// PARITY | checking the parity bit
// STOP   | checking the stop bit, issuing the result pulse
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 5
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    uart_rx_ctrl_if.master        rx_if
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    rx_state_e             r_state;
    rx_state_e             w_state_nxt;
    logic                  w_start;
    logic                  w_bit_end;
    logic [CNT_W-1:0]      w_bit_count;
    logic [PRESCALE_W-1:0] w_edge_count;

    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_fail;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .CNT_W      (CNT_W)
    ) u_cnt (
        .clk          (CLK),
        .rst_n        (Reset),
        .i_en         (r_state != IDLE),
        .i_clr        (r_state == IDLE),
        .i_bit_en     (r_state == DATA),
        .i_prescale   (r_prescale),
        .o_edge_count (w_edge_count),
        .o_bit_count  (w_bit_count),
        .o_bit_end    (w_bit_end)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!RX_IN) begin
                    w_state_nxt = START;
                    w_start     = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = rx_if.Sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_bit_end && (w_bit_count == CNT_W'(DATA_WIDTH - 1))) begin
                    w_state_nxt = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_prescale   <= PRESCALE_W'(PRESCALE_8);
            r_par_en     <= 1'b0;
            r_par_typ    <= PAR_EVEN;
            r_shift      <= '0;
            r_par_fail   <= 1'b0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            if (w_start) begin
                r_prescale <= Prescale;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_par_fail <= 1'b0;
            end
            // LSB arrives first, so after DATA_WIDTH shifts it sits in bit 0
            if (r_state == DATA && w_bit_end) begin
                r_shift <= {rx_if.Sampled_bit, r_shift[DATA_WIDTH-1:1]};
            end
            if (r_state == PARITY && w_bit_end) begin
                r_par_fail <= rx_if.Sampled_bit != ((^r_shift) ^ r_par_typ);
            end
            if (r_state == STOP && w_bit_end) begin
                r_stp_err <= !rx_if.Sampled_bit;
                r_par_err <= r_par_fail;
                if (rx_if.Sampled_bit && !r_par_fail) begin
                    r_data_valid <= 1'b1;
                    r_p_data     <= r_shift;
                end
            end
        end
    end

    assign rx_if.S_EN       = (r_state != IDLE);
    assign rx_if.edge_count = w_edge_count;
    assign rx_if.P_DATA     = r_p_data;
    assign rx_if.Data_Valid = r_data_valid;
    assign rx_if.Par_Err    = r_par_err;
    assign rx_if.Stp_Err    = r_stp_err;

    // The sampler only strobes while the controller has it enabled
    a_sampled_in_frame: assert property (@(posedge CLK) disable iff (!Reset)
        rx_if.sampled |-> rx_if.S_EN);

endmodule
